i2c_target: RTL and testbench
=============================

# i2c_target

I2C target (slave) endpoint that answers transactions issued by the team's `i2c_controller`. It oversamples SCL and SDA on the system clock, detects START, repeated START and STOP, matches a fixed 7-bit address, and then does one of two things:
- receives written bytes and hands them to the user side with a one-cycle strobe;
- serves read bytes requested through a load handshake.

SDA is driven open-drain through an enable. SCL is input-only; the block never stretches the clock.

## Interface
- `ADDR`, default 7'h55: own 7-bit target address.
- `FILTER_LEN`, default 3: glitch-filter stability length in clk cycles. Used only with the filter macro.
- `clk`  input  1  system clock, at least 10× the SCL frequency.
- `rst`  input  1  asynchronous, active-low reset.
- `scl`  input  1  I2C clock from the bus (asynchronous).
- `sda`  input  1  I2C data sampled from the bus (asynchronous).
- `sda_oe`  output  1  1 = pull SDA low; 0 = release.
- `rx_data`  output  8  last received write byte, MSB first on the wire.
- `rx_valid`  output  1  one-cycle strobe when `rx_data` is updated.
- `tx_data`  input  8  byte to send on the next read byte.
- `tx_req`  output  1  one-cycle request for the user to present `tx_data`.
- `busy`  output  1  high from an address match until STOP.

## Operation
- Both inputs pass through a 2-FF synchronizer, then an edge detector.
- Bus event detection:
  - START / repeated START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
- Bit timing: SDA is sampled on the detected SCL rise. `sda_oe` changes only on the detected SCL fall.
- States: IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP.
- IDLE → ADDR on START.
- ADDR shifts in 8 bits (7 address bits + R/W).
  - Match → ADDR_ACK.
  - Mismatch → WAIT_STOP, with `sda_oe` held at 0.
  - General call (address 0) is not supported.
- ADDR_ACK:
  - Drives ACK (`sda_oe`=1) for the 9th SCL period.
  - At that SCL rise, pulses `tx_req` if R/W=1.
  - At the following SCL fall, goes to RX (write) or TX (read).
- RX:
  - Shifts 8 bits, then RX_ACK.
  - At the SCL fall after bit 8: `rx_data` updates, `rx_valid` pulses, `sda_oe`=1.
  - RX_ACK → RX on the next fall, releasing SDA.
- TX:
  - `tx_data` is latched at the SCL fall that starts the byte.
  - `sda_oe` = ~bit, MSB first.
  - After 8 bits, SDA is released and the state goes to TX_ACK.
- TX_ACK samples the master's ACK at the SCL rise.
  - ACK (0) → pulse `tx_req`, then TX.
  - NACK (1) → WAIT_STOP, with no `tx_req`.
- STOP from any state → IDLE, with `sda_oe`=0 and `busy`=0.
- Repeated START from any state → ADDR; `busy` is cleared until the next match.
- `busy` rises in the cycle ADDR_ACK is entered.

## Timing
- Reset (`rst`=0) forces every output to 0 immediately and asynchronously: `sda_oe`, `rx_data`, `rx_valid`, `tx_req`, `busy`. The state goes to IDLE.
- A reset in the middle of a byte releases SDA at once. After release the block waits for a fresh START.
- Input latency: 2 clk (synchronizer) + 1 clk (edge detect). Add `FILTER_LEN` when the filter is enabled.
- `sda_oe` settles within 1 clk after the detected SCL fall. This is well inside the SCL-low phase given the 10× clock ratio.
- `rx_valid` and `tx_req` are exactly one clk wide. There are never two pulses per byte.
- `tx_data` must be stable from the `tx_req` pulse until the next detected SCL fall.
- If a START/STOP and an SCL edge land in the same cycle, the START/STOP takes priority.
- Bit counter is 3 bits, cleared on START and at every ACK phase.

## Configuration
- `I2C_TARGET_FILTER_EN` defined:
  - Each synchronized input passes a stability filter.
  - A new level is accepted only after it has been constant for `FILTER_LEN` consecutive clks.
  - Pulses shorter than that are ignored.
- Not defined:
  - Synchronizer only; `FILTER_LEN` is unused.
  - 1-clk glitches are seen as real edges.

## Test plan
- Write to address 0x55 with data 0xCC, then STOP:
  - ACK is given on the address and on the data byte.
  - `rx_data`=0xCC, with a single `rx_valid` pulse.
  - `busy` is 1 during the transfer and 0 after STOP.
- Write to address 0x2A:
  - `sda_oe` stays 0 for the whole frame.
  - No `rx_valid`; `busy` stays 0.
  - The block is back in IDLE after STOP.
- Read from 0x55 with `tx_data`=0xA5 and master ACK, then `tx_data`=0x3C and master NACK:
  - The bus carries 10100101, then 00111100.
  - Exactly two `tx_req` pulses; WAIT_STOP follows the NACK.
- Write 0x55 with data 0x12, then repeated START, then read 0x55:
  - `rx_data`=0x12.
  - The target re-ACKs the address and enters TX without a STOP.
- Assert `rst` in the middle of a data byte:
  - `sda_oe` goes to 0 in the same cycle, `busy` goes to 0.
  - No ACK is given until a new START.
- Apply a 1-clk SDA low pulse while SCL is high in IDLE:
  - With `I2C_TARGET_FILTER_EN` defined: no START is detected and the block stays in IDLE.
  - Without the macro: a START is detected and the block enters ADDR.

Source files
------------

// File: rtl/i2c_target.sv
// i2c_target: I2C target endpoint with a fixed 7-bit address.
// SCL and SDA are oversampled on clk through a 2-FF synchronizer and an edge detector.
// The block detects START, repeated START and STOP.
// Write bytes are delivered on rx_data with a one-cycle rx_valid strobe.
// Read bytes are requested with a one-cycle tx_req and latched from tx_data.
// SDA is driven open-drain through sda_oe. SCL is never stretched.
//
// Parameters:
//   ADDR        own 7-bit address
//   FILTER_LEN  glitch-filter stability length in clk cycles
// Ports:
//   clk, rst (async, active low), scl, sda (async bus inputs)
//   sda_oe (1 = pull SDA low), rx_data/rx_valid, tx_data/tx_req, busy
// Build option:
//   define I2C_TARGET_FILTER_EN to add a stability filter after the synchronizer.
module i2c_target #(
  parameter logic [6:0]  ADDR       = 7'h55,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  input  logic       sda,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy
);

  typedef enum logic [2:0] {
    StIdle, StAddr, StAddrAck, StRx, StRxAck, StTx, StTxAck, StWaitStop
  } state_e;

  // Bit 1 = SCL, bit 0 = SDA. The reset value is the idle bus level, so no false edges occur.
  logic [1:0] sync1_q, sync2_q, line, line_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
    end else begin
      sync1_q <= {scl, sda};
      sync2_q <= sync1_q;
    end
  end

`ifdef I2C_TARGET_FILTER_EN
  localparam int unsigned CntW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(FILTER_LEN - 1);

  logic [1:0]           filt_q;
  logic [1:0][CntW-1:0] stab_q;

  // A new level is accepted once it has differed from the filtered level for FILTER_LEN clks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_q <= 2'b11;
      stab_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          stab_q[i] <= '0;
        end else if (stab_q[i] == CntMax) begin
          filt_q[i] <= sync2_q[i];
          stab_q[i] <= '0;
        end else begin
          stab_q[i] <= stab_q[i] + 1'b1;
        end
      end
    end
  end

  assign line = filt_q;
`else
  logic unused_filter_len;
  assign unused_filter_len = ^FILTER_LEN;
  assign line = sync2_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) line_q <= 2'b11;
    else      line_q <= line;
  end

  logic scl_rise, scl_fall, start_det, stop_det, sda_now;
  assign sda_now   = line[0];
  assign scl_rise  = line[1] & ~line_q[1];
  assign scl_fall  = ~line[1] & line_q[1];
  assign start_det = line[1] & line_q[1] & line_q[0] & ~line[0];
  assign stop_det  = line[1] & line_q[1] & ~line_q[0] & line[0];

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  // Set after the 8th bit of a byte. In TX_ACK it instead marks a master ACK.
  logic       full_q, full_d;
  logic [7:0] shreg_q, shreg_d;
  logic       sda_oe_q, sda_oe_d, rx_valid_q, rx_valid_d, tx_req_q, tx_req_d;
  logic       busy_q, busy_d;
  logic [7:0] rx_data_q, rx_data_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      full_q     <= 1'b0;
      shreg_q    <= '0;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      full_q     <= full_d;
      shreg_q    <= shreg_d;
      sda_oe_q   <= sda_oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    full_d     = full_q;
    shreg_d    = shreg_q;
    sda_oe_d   = sda_oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    busy_d     = busy_q;
    // Bus conditions override any SCL edge seen in the same cycle.
    if (stop_det) begin
      state_d  = StIdle;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d  = StAddr;
      cnt_d    = '0;
      full_d   = 1'b0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        StAddr, StRx: begin
          if (scl_rise && !full_q) begin
            shreg_d = {shreg_q[6:0], sda_now};
            cnt_d   = cnt_q + 3'd1;
            full_d  = (cnt_q == 3'd7);
          end else if (scl_fall && full_q) begin
            cnt_d  = '0;
            full_d = 1'b0;
            if (state_q == StRx) begin
              rx_data_d  = shreg_q;
              rx_valid_d = 1'b1;
              sda_oe_d   = 1'b1;
              state_d    = StRxAck;
            end else if (shreg_q[7:1] == ADDR) begin
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
              state_d  = StAddrAck;
            end else begin
              state_d = StWaitStop;
            end
          end
        end
        StAddrAck: begin
          // shreg_q still holds the address byte; bit 0 is R/W.
          if (scl_rise && shreg_q[0]) tx_req_d = 1'b1;
          if (scl_fall) begin
            if (shreg_q[0]) begin
              shreg_d  = tx_data;
              sda_oe_d = ~tx_data[7];
              state_d  = StTx;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = StRx;
            end
          end
        end
        StRxAck: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = StRx;
          end
        end
        StTx: begin
          if (scl_rise && !full_q) begin
            cnt_d  = cnt_q + 3'd1;
            full_d = (cnt_q == 3'd7);
          end else if (scl_fall) begin
            if (full_q) begin
              sda_oe_d = 1'b0;
              cnt_d    = '0;
              full_d   = 1'b0;
              state_d  = StTxAck;
            end else begin
              shreg_d  = {shreg_q[6:0], 1'b0};
              sda_oe_d = ~shreg_q[6];
            end
          end
        end
        StTxAck: begin
          if (scl_rise && !full_q) begin
            if (!sda_now) begin
              tx_req_d = 1'b1;
              full_d   = 1'b1;
            end else begin
              state_d = StWaitStop;
            end
          end else if (scl_fall && full_q) begin
            full_d   = 1'b0;
            shreg_d  = tx_data;
            sda_oe_d = ~tx_data[7];
            state_d  = StTx;
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_oe   = sda_oe_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_req   = tx_req_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Self-checking bench for i2c_target.
// It acts as a bus master on SCL/SDA with a wired-AND SDA line.
// A table of directed transactions and a set of random transactions are checked against
// expectations derived from the protocol rules.
// Hand-written sequences cover repeated START, reset mid-byte and the 1-clk SDA glitch.
module tb_i2c_target;

  localparam logic [6:0] OwnAddr = 7'h55;
  localparam int Q = 10;  // quarter SCL period in clk cycles

  typedef struct {
    logic [6:0]      addr;
    logic            rw;
    int              n;
    logic [3:0][7:0] d;
    logic            exp_ack;
    logic [7:0]      exp_rx;
    int              exp_rxv;
    int              exp_txreq;
    logic            exp_busy;
  } txn_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe, rx_valid, tx_req, busy;
  logic [7:0] rx_data;
  logic [7:0] tx_data = 8'h00;

  int n_vec = 0;
  int n_err = 0;
  int rxv_cnt = 0;
  int txr_cnt = 0;
  int oe_cnt = 0;
  logic [7:0] model_rx = 8'h00;

  assign sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target #(.ADDR(OwnAddr), .FILTER_LEN(3)) dut (
    .clk      (clk),
    .rst      (rst_n),
    .scl      (scl_m),
    .sda      (sda_line),
    .sda_oe   (sda_oe),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_req   (tx_req),
    .busy     (busy)
  );

  // Count high cycles so that a widened pulse shows up as an extra count.
  always @(posedge clk) begin
    if (rx_valid) rxv_cnt <= rxv_cnt + 1;
    if (tx_req)   txr_cnt <= txr_cnt + 1;
    if (sda_oe)   oe_cnt  <= oe_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_xfer(input logic b, output logic r);
    tick(Q); sda_m = b;
    tick(Q); scl_m = 1'b1;
    tick(Q); r = sda_line;
    tick(Q); scl_m = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic [7:0] got);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(b[i], r);
      got[i] = r;
    end
  endtask

  task automatic bus_start();
    tick(Q); sda_m = 1'b1;
    tick(Q); scl_m = 1'b1;
    tick(Q); sda_m = 1'b0;
    tick(Q); scl_m = 1'b0;
  endtask

  task automatic bus_stop();
    tick(Q); sda_m = 1'b0;
    tick(Q); scl_m = 1'b1;
    tick(Q); sda_m = 1'b1;
    tick(Q);
  endtask

  // Protocol-level expectations: only the own address is answered; writes deliver every byte;
  // reads request one byte at the address ACK and one per master ACK (the last byte is NACKed).
  function automatic txn_t model(input txn_t t);
    logic hit;
    hit = (t.addr == OwnAddr);
    t.exp_ack  = hit;
    t.exp_busy = hit;
    if (!t.rw) begin
      t.exp_rxv   = hit ? t.n : 0;
      t.exp_rx    = hit ? t.d[t.n-1] : model_rx;
      t.exp_txreq = 0;
    end else begin
      t.exp_rxv   = 0;
      t.exp_rx    = model_rx;
      t.exp_txreq = hit ? t.n : 0;
    end
    model_rx = t.exp_rx;
    return t;
  endfunction

  task automatic run_txn(input txn_t t, input string tag);
    int rxv0, txr0, oe0;
    logic [7:0] got;
    logic ack;
    rxv0 = rxv_cnt; txr0 = txr_cnt; oe0 = oe_cnt;
    if (t.rw) tx_data = t.d[0];
    bus_start();
    send_byte({t.addr, t.rw}, got);
    bit_xfer(1'b1, ack);
    check({tag, " addr_ack"}, 32'(!ack), 32'(t.exp_ack));
    for (int i = 0; i < t.n; i++) begin
      if (t.rw) begin
        send_byte(8'hFF, got);
        check({tag, " rd_byte"}, 32'(got), t.exp_ack ? 32'(t.d[i]) : 32'hFF);
        if (i + 1 < t.n) tx_data = t.d[i+1];
        bit_xfer(i + 1 == t.n, ack);
      end else begin
        send_byte(t.d[i], got);
        bit_xfer(1'b1, ack);
        check({tag, " wr_ack"}, 32'(!ack), 32'(t.exp_ack));
      end
    end
    if (t.rw) begin
      // The target must stay silent after the master's NACK.
      send_byte(8'hFF, got);
      check({tag, " post_nack"}, 32'(got), 32'hFF);
    end
    check({tag, " busy_in"}, 32'(busy), 32'(t.exp_busy));
    bus_stop();
    tick(8);
    check({tag, " busy_after"}, 32'(busy), 32'd0);
    check({tag, " rx_data"}, 32'(rx_data), 32'(t.exp_rx));
    check({tag, " rx_valid_cnt"}, 32'(rxv_cnt - rxv0), 32'(t.exp_rxv));
    check({tag, " tx_req_cnt"}, 32'(txr_cnt - txr0), 32'(t.exp_txreq));
    if (!t.exp_ack) check({tag, " oe_silent"}, 32'(oe_cnt - oe0), 32'd0);
  endtask

  txn_t tbl [5];
  txn_t rt;
  logic [7:0] got;
  logic ack;
  logic exp_bus;
  int rxv0, txr0, oe0;

  initial begin
    tbl[0] = '{addr: 7'h55, rw: 1'b0, n: 1, d: 32'h000000CC, exp_ack: 1'b1, exp_rx: 8'hCC,
               exp_rxv: 1, exp_txreq: 0, exp_busy: 1'b1};
    tbl[1] = '{addr: 7'h2A, rw: 1'b0, n: 1, d: 32'h00000077, exp_ack: 1'b0, exp_rx: 8'hCC,
               exp_rxv: 0, exp_txreq: 0, exp_busy: 1'b0};
    tbl[2] = '{addr: 7'h55, rw: 1'b1, n: 2, d: 32'h00003CA5, exp_ack: 1'b1, exp_rx: 8'hCC,
               exp_rxv: 0, exp_txreq: 2, exp_busy: 1'b1};
    tbl[3] = '{addr: 7'h55, rw: 1'b0, n: 2, d: 32'h0000F00F, exp_ack: 1'b1, exp_rx: 8'hF0,
               exp_rxv: 2, exp_txreq: 0, exp_busy: 1'b1};
    tbl[4] = '{addr: 7'h2A, rw: 1'b1, n: 1, d: 32'h00000099, exp_ack: 1'b0, exp_rx: 8'hF0,
               exp_rxv: 0, exp_txreq: 0, exp_busy: 1'b0};

    // Reset state
    tick(4);
    check("rst sda_oe", 32'(sda_oe), 32'd0);
    check("rst rx_data", 32'(rx_data), 32'd0);
    check("rst rx_valid", 32'(rx_valid), 32'd0);
    check("rst tx_req", 32'(tx_req), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick(10);

    for (int i = 0; i < 5; i++) run_txn(tbl[i], $sformatf("tbl%0d", i));
    model_rx = tbl[4].exp_rx;

    // Write 0x12, repeated START, read back without an intervening STOP.
    rxv0 = rxv_cnt; txr0 = txr_cnt;
    bus_start();
    send_byte({OwnAddr, 1'b0}, got);
    bit_xfer(1'b1, ack);
    check("rs wr addr_ack", 32'(ack), 32'd0);
    send_byte(8'h12, got);
    bit_xfer(1'b1, ack);
    check("rs wr data_ack", 32'(ack), 32'd0);
    tx_data = 8'h5A;
    bus_start();
    check("rs busy_clr", 32'(busy), 32'd0);
    send_byte({OwnAddr, 1'b1}, got);
    bit_xfer(1'b1, ack);
    check("rs rd addr_ack", 32'(ack), 32'd0);
    check("rs busy_set", 32'(busy), 32'd1);
    send_byte(8'hFF, got);
    check("rs rd byte", 32'(got), 32'h5A);
    bit_xfer(1'b1, ack);
    bus_stop();
    tick(8);
    check("rs rx_data", 32'(rx_data), 32'h12);
    check("rs rx_valid_cnt", 32'(rxv_cnt - rxv0), 32'd1);
    check("rs tx_req_cnt", 32'(txr_cnt - txr0), 32'd1);
    model_rx = 8'h12;

    // 1-clk SDA low pulse while SCL is high; SCL falls as SDA returns so no STOP is formed.
    tick(20);
    sda_m = 1'b0;
    tick(1);
    sda_m = 1'b1;
    scl_m = 1'b0;
    send_byte({OwnAddr, 1'b0}, got);
    bit_xfer(1'b1, ack);
`ifdef I2C_TARGET_FILTER_EN
    exp_bus = 1'b1;
`else
    exp_bus = 1'b0;
`endif
    check("glitch addr_ack", 32'(ack), 32'(exp_bus));
    bus_stop();
    tick(8);
    check("glitch busy_after", 32'(busy), 32'd0);

    // Reset in the middle of a read byte of 0x00 (target pulling SDA low).
    tx_data = 8'h00;
    bus_start();
    send_byte({OwnAddr, 1'b1}, got);
    bit_xfer(1'b1, ack);
    check("mrst addr_ack", 32'(ack), 32'd0);
    for (int i = 0; i < 3; i++) bit_xfer(1'b1, ack);
    tick(Q); tick(Q); scl_m = 1'b1; tick(Q);
    check("mrst oe_before", 32'(sda_oe), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mrst oe_async", 32'(sda_oe), 32'd0);
    check("mrst busy_async", 32'(busy), 32'd0);
    check("mrst rx_data_async", 32'(rx_data), 32'd0);
    tick(2);
    rst_n = 1'b1;
    oe0 = oe_cnt;
    tick(Q); scl_m = 1'b0;
    for (int i = 0; i < 4; i++) bit_xfer(1'b1, ack);
    bit_xfer(1'b1, ack);
    check("mrst no_ack", 32'(ack), 32'd1);
    check("mrst oe_silent", 32'(oe_cnt - oe0), 32'd0);
    bus_stop();
    tick(8);
    model_rx = 8'h00;
    rt = model(tbl[0]);
    run_txn(rt, "mrst recover");

    // Random transactions against the protocol model.
    for (int k = 0; k < 12; k++) begin
      rt.addr = ($urandom_range(0, 1) == 1) ? OwnAddr : 7'($urandom);
      rt.rw   = 1'($urandom);
      rt.n    = $urandom_range(1, 3);
      rt.d    = 32'($urandom);
      rt = model(rt);
      run_txn(rt, $sformatf("rnd%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
